// File: rtl/cpu_fetch_ctrl.sv
// Fetch sequencer: walks pc over the instruction memory, captures each frame
// and issues its a/b/c/op fields downstream with a valid/ready handshake.
module cpu_fetch_ctrl #(
  parameter int ADDR_W   = 3,
  parameter int FRAME_W  = 13,
  parameter int PROG_LEN = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [FRAME_W-1:0] mem_data,
  output logic [3:0]        a_out,
  output logic [3:0]        b_out,
  output logic              c_out,
  output logic [3:0]        op_out,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CAPTURE,
    S_ISSUE,
    S_DONE
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(PROG_LEN - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [3:0]        a_q, b_q, op_q;
  logic              c_q;
  logic              cap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Field registers only move on the CAPTURE edge, so they hold through stalls
  // and keep their last values across an abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= '0;
      b_q  <= '0;
      c_q  <= 1'b0;
      op_q <= '0;
    end else if (cap) begin
      a_q  <= mem_data[12:9];
      b_q  <= mem_data[8:5];
      c_q  <= mem_data[4];
      op_q <= mem_data[3:0];
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cap     = 1'b0;
    case (state_q)
      S_IDLE: begin
        pc_d = '0;
        if (start && !abort) state_d = S_FETCH;
      end
      S_FETCH:   state_d = S_CAPTURE;
      S_CAPTURE: begin
        cap     = 1'b1;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (instr_ready) begin
          if (pc_q == LAST_PC) begin
            state_d = S_DONE;
          end else begin
            pc_d    = pc_q + ADDR_W'(1);
            state_d = S_FETCH;
          end
        end
      end
      S_DONE: begin
        pc_d    = '0;
        state_d = S_IDLE;
      end
      default: begin
        pc_d    = '0;
        state_d = S_IDLE;
      end
    endcase
    // Abort wins over acceptance and over a pending capture.
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      pc_d    = '0;
      cap     = 1'b0;
    end
  end

  assign mem_en      = (state_q == S_FETCH);
  assign instr_valid = (state_q == S_ISSUE);
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign mem_addr    = pc_q;
  assign pc          = pc_q;
  assign a_out       = a_q;
  assign b_out       = b_q;
  assign c_out       = c_q;
  assign op_out      = op_q;

endmodule

// File: tb/tb_cpu_fetch_ctrl.sv
// Directed bench for cpu_fetch_ctrl: cycle table for a full run plus
// hand-written stall, abort, start-while-busy and reset sequences.
module tb_cpu_fetch_ctrl;
  localparam int ADDR_W   = 3;
  localparam int FRAME_W  = 13;
  localparam int PROG_LEN = 6;

  logic              clk = 1'b0;
  logic              rst_n, start, abort, instr_ready;
  logic              mem_en, instr_valid, busy, done, c_out;
  logic [ADDR_W-1:0] mem_addr, pc;
  logic [FRAME_W-1:0] mem_data;
  logic [3:0]        a_out, b_out, op_out;
  logic [FRAME_W-1:0] mem [8];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int exp_a  [6] = '{2, 2, 4, 8, 7, 1};
  int exp_b  [6] = '{8, 7, 3, 2, 10, 8};
  int exp_c  [6] = '{1, 0, 0, 1, 0, 0};
  int exp_op [6] = '{0, 1, 1, 2, 4, 7};

  typedef struct {
    bit start;
    bit ready;
    bit en;
    bit vld;
    bit bsy;
    bit dn;
    int pc;
    int idx;
  } vec_t;
  vec_t tbl [21];

  cpu_fetch_ctrl #(.ADDR_W(ADDR_W), .FRAME_W(FRAME_W), .PROG_LEN(PROG_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_data(mem_data),
    .a_out(a_out), .b_out(b_out), .c_out(c_out), .op_out(op_out),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .pc(pc), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_en) mem_data <= mem[mem_addr];

  function automatic vec_t mk(bit s, bit r, bit en, bit vld, bit bsy, bit dn, int p, int idx);
    vec_t v;
    v.start = s; v.ready = r; v.en = en; v.vld = vld;
    v.bsy = bsy; v.dn = dn; v.pc = p; v.idx = idx;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_ctl(string nm, bit en, bit vld, bit bsy, bit dn, int p);
    chk({nm, ".mem_en"}, 32'(mem_en), 32'(en));
    chk({nm, ".valid"},  32'(instr_valid), 32'(vld));
    chk({nm, ".busy"},   32'(busy), 32'(bsy));
    chk({nm, ".done"},   32'(done), 32'(dn));
    chk({nm, ".pc"},     32'(pc), 32'(p));
    chk({nm, ".addr"},   32'(mem_addr), 32'(p));
  endtask

  task automatic chk_fields(string nm, int i);
    chk({nm, ".a"},  32'(a_out),  32'(exp_a[i]));
    chk({nm, ".b"},  32'(b_out),  32'(exp_b[i]));
    chk({nm, ".c"},  32'(c_out),  32'(exp_c[i]));
    chk({nm, ".op"}, 32'(op_out), 32'(exp_op[i]));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Called in IDLE; leaves the bench in cycle 1 (FETCH of address 0).
  task automatic begin_run(string nm);
    cyc   = 0;
    start = 1'b1;
    chk({nm, ".idle_busy"}, 32'(busy), 32'd0);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(string nm, int exp_cyc);
    int lim;
    lim = cyc + 60;
    while (done !== 1'b1 && cyc < lim) tick();
    chk({nm, ".done_cycle"}, 32'(cyc), 32'(exp_cyc));
    tick();
    chk({nm, ".after_busy"}, 32'(busy), 32'd0);
    chk({nm, ".after_pc"}, 32'(pc), 32'd0);
  endtask

  initial begin
    int nf;
    for (int i = 0; i < 6; i++)
      mem[i] = {4'(exp_a[i]), 4'(exp_b[i]), 1'(exp_c[i]), 4'(exp_op[i])};
    mem[6] = '1;
    mem[7] = '1;

    tbl[0] = mk(1, 1, 0, 0, 0, 0, 0, -1);
    for (int i = 0; i < 6; i++) begin
      tbl[3*i+1] = mk(0, 1, 1, 0, 1, 0, i, -1);
      tbl[3*i+2] = mk(0, 1, 0, 0, 1, 0, i, -1);
      tbl[3*i+3] = mk(0, 1, 0, 1, 1, 0, i, i);
    end
    tbl[19] = mk(0, 1, 0, 0, 1, 1, 5, -1);
    tbl[20] = mk(0, 1, 0, 0, 0, 0, 0, -1);

    // Reset asserted mid-cycle, then idle with start low.
    rst_n = 1'b1; start = 1'b0; abort = 1'b0; instr_ready = 1'b1;
    #7 rst_n = 1'b0;
    #1;
    chk_ctl("reset", 0, 0, 0, 0, 0);
    chk({"reset", ".fields"}, 32'({a_out, b_out, c_out, op_out}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    chk_ctl("idle", 0, 0, 0, 0, 0);

    // Full program, ready tied high.
    cyc = 0;
    for (int k = 0; k < 21; k++) begin
      start       = tbl[k].start;
      instr_ready = tbl[k].ready;
      chk_ctl($sformatf("run[%0d]", k), tbl[k].en, tbl[k].vld, tbl[k].bsy, tbl[k].dn, tbl[k].pc);
      if (tbl[k].idx >= 0) chk_fields($sformatf("run[%0d]", k), tbl[k].idx);
      tick();
    end
    start = 1'b0;

    // Backpressure: 5 stall cycles on the second instruction.
    begin_run("stall");
    while (cyc < 6) tick();
    instr_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      chk_ctl($sformatf("stall[%0d]", s), 0, 1, 1, 0, 1);
      chk_fields($sformatf("stall[%0d]", s), 1);
      tick();
    end
    instr_ready = 1'b1;
    chk_ctl("stall_rel", 0, 1, 1, 0, 1);
    chk_fields("stall_rel", 1);
    wait_done("stall", 24);

    // Abort in ISSUE at pc = 3, then replay from 0.
    begin_run("abort");
    while (cyc < 12) tick();
    chk_ctl("pre_abort", 0, 1, 1, 0, 3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_ctl("abort", 0, 0, 0, 0, 0);
    chk_fields("abort_hold", 3);
    for (int s = 0; s < 3; s++) begin
      tick();
      chk_ctl($sformatf("post_abort[%0d]", s), 0, 0, 0, 0, 0);
    end
    begin_run("replay");
    chk_ctl("replay", 1, 0, 1, 0, 0);
    tick();
    tick();
    chk_ctl("replay_iss", 0, 1, 1, 0, 0);
    chk_fields("replay_iss", 0);
    wait_done("replay", 19);

    // start while busy must not restart the sequence.
    begin_run("busy_start");
    nf = 0;
    while (done !== 1'b1 && cyc < 60) begin
      start = (cyc == 8);
      if (mem_en) begin
        chk($sformatf("fetch_addr[%0d]", nf), 32'(mem_addr), 32'(nf));
        nf++;
      end
      tick();
    end
    start = 1'b0;
    chk("busy_start.fetches", 32'(nf), 32'd6);
    chk("busy_start.done_cycle", 32'(cyc), 32'd19);
    tick();
    chk_ctl("busy_start_end", 0, 0, 0, 0, 0);

    // Reset mid-run during CAPTURE at pc = 4.
    begin_run("mid_rst");
    while (cyc < 14) tick();
    chk_ctl("pre_rst", 0, 0, 1, 0, 4);
    #2 rst_n = 1'b0;
    #1;
    chk_ctl("rst_async", 0, 0, 0, 0, 0);
    chk({"rst_async", ".fields"}, 32'({a_out, b_out, c_out, op_out}), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int s = 0; s < 3; s++) begin
      tick();
      chk_ctl($sformatf("post_rst[%0d]", s), 0, 0, 0, 0, 0);
    end
    begin_run("post_rst_run");
    chk_ctl("post_rst_run", 1, 0, 1, 0, 0);
    wait_done("post_rst_run", 19);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cpu_fetch_ctrl.md
# cpu_fetch_ctrl

Fetch sequencer for the 4-bit CPU. It steps a program counter through the instruction memory, drives its read enable and address, and captures each registered 13-bit instruction frame. It splits each frame into ALU operand/opcode fields and hands them downstream with a valid/ready handshake. It sits between the top-level start control and the instruction memory on one side and the ALU/execute stage on the other.

## Interface
- ADDR_W, 3, instruction memory address width
- FRAME_W, 13, instruction frame width; fixed layout {a[12:9], b[8:5], c[4], op[3:0]}
- PROG_LEN, 6, number of instructions executed per run; legal range 1..2^ADDR_W

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a run from address 0; sampled only in IDLE
- abort  in  1  synchronous; ends the run at the next edge with no done pulse
- mem_en  out  1  instruction memory read enable
- mem_addr  out  ADDR_W  instruction memory address (= pc)
- mem_data  in  FRAME_W  registered memory output; valid the cycle after mem_en
- a_out  out  4  operand A field
- b_out  out  4  operand B field
- c_out  out  1  carry-in field
- op_out  out  4  ALU opcode field
- instr_valid  out  1  fields valid; held until accepted
- instr_ready  in  1  downstream accepts when instr_valid & instr_ready at an edge
- pc  out  ADDR_W  current program counter
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse after the last instruction is accepted

## Operation
- States: IDLE, FETCH, CAPTURE, ISSUE, DONE.
- IDLE: pc = 0, mem_en = 0, instr_valid = 0. If start = 1, go to FETCH.
- FETCH: mem_en = 1, mem_addr = pc, for exactly one cycle. Go to CAPTURE.
- CAPTURE: mem_en = 0. At the end-of-cycle edge, latch mem_data into a_out/b_out/c_out/op_out. Go to ISSUE.
- ISSUE: instr_valid = 1, fields stable. Remain in ISSUE while instr_ready = 0. On the accepting edge:
  - if pc == PROG_LEN-1, go to DONE;
  - otherwise pc <= pc+1 and go to FETCH.
- DONE: done = 1 for one cycle, pc <= 0. Go to IDLE.
- abort = 1 in any non-IDLE state: go to IDLE at the next edge. Effects:
  - instr_valid and mem_en drop;
  - pc <= 0;
  - field registers keep their last values;
  - no done pulse.
  - abort takes priority over acceptance in the same cycle.
- start while busy is ignored. start and abort together in IDLE: stay in IDLE.
- Fields pass through undecoded; opcode legality is the execute stage's concern.
- pc never exceeds PROG_LEN-1, so there is no address wrap-around. With PROG_LEN = 2^ADDR_W, the last address is all-ones and the increment is never taken.

## Timing
- Reset (async assert, sync release) forces:
  - IDLE;
  - pc = 0, mem_addr = 0;
  - mem_en = 0, instr_valid = 0, busy = 0, done = 0;
  - a_out = b_out = c_out = op_out = 0.
- Reset mid-run discards the in-flight instruction; no done pulse.
- Cycle 0: start sampled high at its end edge.
- Cycle 1: FETCH (mem_en = 1).
- Cycle 2: CAPTURE.
- Cycle 3: first instr_valid = 1, i.e. 3 cycles from start edge to valid.
- Per-instruction issue interval is 3 cycles with instr_ready tied high; each stall cycle adds 1.
- Full run with instr_ready = 1: 3·PROG_LEN cycles in FETCH/CAPTURE/ISSUE, plus 1 DONE cycle. busy is high for all of them.
- mem_addr changes only on edges where pc changes; it is stable throughout FETCH and CAPTURE.
- instr_valid must not drop and fields must not change while stalled.

## Test plan
- Reset then idle: rst_n low mid-cycle. All outputs go to 0 immediately and remain there with start = 0.
- Full program, instr_ready = 1, PROG_LEN = 6, memory loaded with the standard 6-frame test program. Required issues, in order:
  - (a,b,c,op) = (2,8,1,0), (2,7,0,1), (4,3,0,1), (8,2,1,2), (7,10,0,4), (1,8,0,7);
  - instr_valid high in cycles 3, 6, 9, 12, 15, 18;
  - done pulse in cycle 19; busy low from cycle 20.
- Backpressure: hold instr_ready = 0 for 5 cycles on the second instruction. instr_valid and (2,7,0,1) stay stable; mem_en stays 0; pc = 1 throughout; the run ends 5 cycles later than the unstalled run.
- Abort: assert abort while in ISSUE at pc = 3. Next cycle is IDLE with busy = 0, pc = 0, instr_valid = 0, and no done pulse. A new start replays from address 0.
- start while busy: pulse start during pc = 2. There is no restart and the address sequence is unchanged.
- Reset mid-run: drop rst_n during CAPTURE at pc = 4. All outputs return to 0 asynchronously, and after release the block is in IDLE waiting for start.
